// File: rtl/parity_frame_gen.sv
// rtl/parity_frame_gen.sv - serial parity framer with generate and check modes
//
// Groups qualified serial bits into frames of DATA_W bits. In generate mode a
// parity bit is produced per frame; in check mode the bit following each frame
// is compared with the computed parity and mismatches are counted.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_i         serial data / parity bit
//   in_valid_i   qualifies in_i this cycle
//   odd_i        0 = even, 1 = odd parity (sampled at first data bit)
//   check_i      0 = generate, 1 = check (sampled at first data bit)
//   err_clr_i    synchronous clear of err_cnt_o
//   parity_o     running mode-adjusted parity of the current frame
//   par_valid_o  one-cycle pulse: frame complete, par_out_o valid
//   par_out_o    frame parity (generate) / expected parity (check)
//   par_err_o    one-cycle pulse with par_valid_o on parity mismatch
//   err_cnt_o    saturating parity error count
//   busy_o       high while a frame is partially received
module parity_frame_gen #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_i,
  input  logic                 in_valid_i,
  input  logic                 odd_i,
  input  logic                 check_i,
  input  logic                 err_clr_i,
  output logic                 parity_o,
  output logic                 par_valid_o,
  output logic                 par_out_o,
  output logic                 par_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [0:0] S_DATA = 1'b0;
  localparam logic [0:0] S_PAR  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 acc_q, acc_d;
  logic                 odd_q, odd_d;
  logic                 chk_q, chk_d;
  logic                 parity_q, parity_d;
  logic                 par_valid_q, par_valid_d;
  logic                 par_out_q, par_out_d;
  logic                 par_err_q, par_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 busy_q, busy_d;
  logic                 err_inc;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    odd_d       = odd_q;
    chk_d       = chk_q;
    par_out_d   = par_out_q;
    par_valid_d = 1'b0;
    par_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    err_inc     = 1'b0;

    if (in_valid_i) begin
      if (state_q == S_PAR) begin
        par_valid_d = 1'b1;
        par_err_d   = in_i ^ par_out_q;
        err_inc     = in_i ^ par_out_q;
        state_d     = S_DATA;
      end else begin
        // Mode is captured only on the first bit so mid-frame toggles are inert.
        if (bit_cnt_q == '0) begin
          odd_d = odd_i;
          chk_d = check_i;
          acc_d = in_i;
        end else begin
          acc_d = acc_q ^ in_i;
        end

        if (bit_cnt_q == LAST_BIT) begin
          par_out_d = acc_d ^ odd_d;
          bit_cnt_d = '0;
          if (chk_d) begin
            state_d = S_PAR;
          end else begin
            par_valid_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    // Clear has priority over a coincident error increment.
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

    busy_d   = (state_d == S_PAR) || (bit_cnt_d != '0);
    parity_d = busy_d & (acc_d ^ odd_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DATA;
      bit_cnt_q   <= '0;
      acc_q       <= 1'b0;
      odd_q       <= 1'b0;
      chk_q       <= 1'b0;
      parity_q    <= 1'b0;
      par_valid_q <= 1'b0;
      par_out_q   <= 1'b0;
      par_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      odd_q       <= odd_d;
      chk_q       <= chk_d;
      parity_q    <= parity_d;
      par_valid_q <= par_valid_d;
      par_out_q   <= par_out_d;
      par_err_q   <= par_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign parity_o    = parity_q;
  assign par_valid_o = par_valid_q;
  assign par_out_o   = par_out_q;
  assign par_err_o   = par_err_q;
  assign err_cnt_o   = err_cnt_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_parity_frame_gen.sv
// tb/tb_parity_frame_gen.sv - self-checking bench for parity_frame_gen
module tb_parity_frame_gen;

  localparam int DATA_W    = 4;
  localparam int ERR_CNT_W = 2;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_b = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 odd = 1'b0;
  logic                 check = 1'b0;
  logic                 err_clr = 1'b0;
  logic                 parity;
  logic                 par_valid;
  logic                 par_out;
  logic                 par_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  // Reference model: collected frame bits as a count of ones, mode latched per frame.
  int m_n;
  int m_ones;
  bit m_odd;
  bit m_chk;
  bit m_wait;
  bit m_pout;
  int m_cnt;
  bit e_valid;
  bit e_err;

  parity_frame_gen #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_i       (in_b),
    .in_valid_i (in_valid),
    .odd_i      (odd),
    .check_i    (check),
    .err_clr_i  (err_clr),
    .parity_o   (parity),
    .par_valid_o(par_valid),
    .par_out_o  (par_out),
    .par_err_o  (par_err),
    .err_cnt_o  (err_cnt),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ones = 0; m_odd = 0; m_chk = 0; m_wait = 0; m_pout = 0;
    m_cnt = 0; e_valid = 0; e_err = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit o, input bit c, input bit clr);
    e_valid = 0;
    e_err   = 0;
    if (v) begin
      if (m_wait) begin
        e_valid = 1;
        e_err   = (b != m_pout);
        m_wait  = 0;
        if (e_err && m_cnt < ERR_MAX) m_cnt++;
      end else begin
        if (m_n == 0) begin
          m_odd = o; m_chk = c; m_ones = 0;
        end
        m_ones += b;
        m_n++;
        if (m_n == DATA_W) begin
          m_pout = ((m_ones % 2) != 0) ^ m_odd;
          m_n = 0;
          if (m_chk) m_wait = 1;
          else e_valid = 1;
        end
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic compare_all(input string tag);
    bit m_busy;
    bit m_par;
    m_busy = m_wait || (m_n != 0);
    m_par  = m_busy ? ((((m_ones % 2) != 0) ^ m_odd)) : 1'b0;
    expect_eq({tag, ".par_valid"}, int'(par_valid), int'(e_valid));
    expect_eq({tag, ".par_err"},   int'(par_err),   int'(e_err));
    expect_eq({tag, ".par_out"},   int'(par_out),   int'(m_pout));
    expect_eq({tag, ".err_cnt"},   int'(err_cnt),   m_cnt);
    expect_eq({tag, ".busy"},      int'(busy),      int'(m_busy));
    expect_eq({tag, ".parity"},    int'(parity),    int'(m_par));
  endtask

  task automatic step(input string tag, input bit v, input bit b, input bit o,
                      input bit c, input bit clr);
    @(negedge clk);
    in_valid = v; in_b = b; odd = o; check = c; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, b, o, c, clr);
    compare_all(tag);
  endtask

  task automatic frame(input string tag, input bit [DATA_W-1:0] bits, input bit o, input bit c);
    for (int i = 0; i < DATA_W; i++) step(tag, 1'b1, bits[DATA_W-1-i], o, c, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // generate even, 1,1,0,1
    step("g_even", 1, 1, 0, 0, 0);
    expect_eq("g_even.parity1", int'(parity), 1);
    step("g_even", 1, 1, 0, 0, 0);
    expect_eq("g_even.parity2", int'(parity), 0);
    step("g_even", 1, 0, 0, 0, 0);
    expect_eq("g_even.parity3", int'(parity), 0);
    step("g_even", 1, 1, 0, 0, 0);
    expect_eq("g_even.pulse", int'(par_valid), 1);
    expect_eq("g_even.pout", int'(par_out), 1);
    step("g_even_idle", 0, 0, 0, 0, 0);
    expect_eq("g_even.pulse_len", int'(par_valid), 0);

    // odd frame then back-to-back even zero frame
    frame("g_odd", 4'b1101, 1, 0);
    expect_eq("g_odd.pout", int'(par_out), 0);
    frame("g_b2b", 4'b0000, 0, 0);
    expect_eq("g_b2b.pulse", int'(par_valid), 1);
    expect_eq("g_b2b.pout", int'(par_out), 0);

    // check even: good parity, then bad parity
    frame("c_good", 4'b1000, 0, 1);
    expect_eq("c_good.busy_wait", int'(busy), 1);
    step("c_good_par", 1, 1, 0, 1, 0);
    expect_eq("c_good.err", int'(par_err), 0);
    frame("c_bad", 4'b1000, 0, 1);
    step("c_bad_par", 1, 0, 0, 1, 0);
    expect_eq("c_bad.err", int'(par_err), 1);
    expect_eq("c_bad.cnt", int'(err_cnt), 1);

    // saturation: counter at 1 already, four more errors, then clear with the sixth
    for (int k = 0; k < 4; k++) begin
      frame("sat", 4'b0110, 0, 1);
      step("sat_par", 1, 1, 0, 1, 0);
    end
    expect_eq("sat.cnt", int'(err_cnt), ERR_MAX);
    frame("sat_clr", 4'b0110, 0, 1);
    step("sat_clr_par", 1, 1, 0, 1, 1);
    expect_eq("sat_clr.err", int'(par_err), 1);
    expect_eq("sat_clr.cnt", int'(err_cnt), 0);

    // gapped generate frame 1,0,1,1 with mode toggles mid-frame
    step("gap", 1, 1, 0, 0, 0);
    for (int i = 1; i < DATA_W; i++) begin
      for (int g = 0; g < 3; g++) begin
        step("gap_idle", 0, 0, (g % 2) == 0, 1, 0);
        expect_eq("gap.busy", int'(busy), 1);
      end
      step("gap", 1, (i == 1) ? 1'b0 : 1'b1, i[0], i[1], 0);
    end
    expect_eq("gap.pulse", int'(par_valid), 1);
    expect_eq("gap.pout", int'(par_out), 1);

    // reset mid-frame
    step("rst_pre", 1, 1, 0, 0, 0);
    step("rst_pre", 1, 1, 0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    frame("post_rst", 4'b1000, 0, 0);
    expect_eq("post_rst.pout", int'(par_out), 1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
